// File: rtl/iopage_ctl_pkg.sv
// Shared types and constants for the CPU-side I/O page initiator.
// Widths, default timing and the controller state encoding live here.
package iopage_pkg;

    localparam int IOPAGE_AW   = 13;
    localparam int IOPAGE_DW   = 16;
    localparam int SETTLE_DEF  = 1;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } iopage_state_e;

    // Byte writes replicate the low byte on both lanes so the addressed
    // responder can pick whichever half matches addr[0].
    function automatic logic [IOPAGE_DW-1:0] lane_dup(
        input logic                 byte_op,
        input logic [IOPAGE_DW-1:0] wdata
    );
        return byte_op ? {wdata[7:0], wdata[7:0]} : wdata;
    endfunction

    function automatic logic misaligned(
        input logic                 byte_op,
        input logic [IOPAGE_AW-1:0] addr
    );
        return !byte_op && addr[0];
    endfunction

endpackage

// File: rtl/iopage_ctl_if.sv
// CPU request/response and I/O page bus signals of the initiator.
// slave = the controller's view, master = the CPU plus responders.
interface iopage_ctl_if;
    import iopage_pkg::*;

    logic                 req;
    logic                 we;
    logic                 byte_op;
    logic [IOPAGE_AW-1:0] addr;
    logic [IOPAGE_DW-1:0] wdata;
    logic [IOPAGE_DW-1:0] rdata;
    logic                 ack;
    logic                 bus_err;
    logic                 busy;

    logic [IOPAGE_AW-1:0] iopage_addr;
    logic [IOPAGE_DW-1:0] iopage_data_out;
    logic                 iopage_rd;
    logic                 iopage_wr;
    logic                 iopage_byte_op;
    logic [IOPAGE_DW-1:0] iopage_data_in;
    logic                 iopage_decode;

    modport slave (
        input  req, we, byte_op, addr, wdata, iopage_data_in, iopage_decode,
        output rdata, ack, bus_err, busy,
               iopage_addr, iopage_data_out, iopage_rd, iopage_wr, iopage_byte_op
    );

    modport master (
        output req, we, byte_op, addr, wdata, iopage_data_in, iopage_decode,
        input  rdata, ack, bus_err, busy,
               iopage_addr, iopage_data_out, iopage_rd, iopage_wr, iopage_byte_op
    );

endinterface

// File: rtl/iopage_ctl.sv
// CPU-side initiator for the 8 KB I/O page: one request becomes one bus
// cycle ending in either an ack with read data or a single bus_err pulse.
module iopage_ctl
    import iopage_pkg::*;
#(
    parameter int SETTLE  = SETTLE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    iopage_ctl_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    iopage_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IOPAGE_DW-1:0] rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [IOPAGE_AW-1:0] addr_q, addr_d;
    logic [IOPAGE_DW-1:0] dout_q, dout_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 byte_q, byte_d;
    logic                 we_q, we_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            we_q    <= we_d;
        end
    end

    // Every output is registered, so each pulse is set on the edge that
    // enters the state in which it must be visible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rd_d    = rd_q;
        wr_d    = 1'b0;
        byte_d  = byte_q;
        we_d    = we_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (misaligned(bus.byte_op, bus.addr)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = bus.addr;
                        we_d    = bus.we;
                        byte_d  = bus.byte_op;
                        dout_d  = lane_dup(bus.byte_op, bus.wdata);
                        cnt_d   = '0;
                        rd_d    = !bus.we;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                cnt_d = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);
                // A late decode still wins over the timeout on the same cycle.
                if (cnt_q >= SETTLE_C && bus.iopage_decode) begin
                    if (!we_q) begin
                        rdata_d = bus.iopage_data_in;
                        rd_d    = 1'b0;
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        wr_d    = 1'b1;
                        state_d = ST_WRITE;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    rd_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_WRITE: begin
                ack_d   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.rdata           = rdata_q;
    assign bus.ack             = ack_q;
    assign bus.bus_err         = err_q;
    assign bus.busy            = busy_q;
    assign bus.iopage_addr     = addr_q;
    assign bus.iopage_data_out = dout_q;
    assign bus.iopage_rd       = rd_q;
    assign bus.iopage_wr       = wr_q;
    assign bus.iopage_byte_op  = byte_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(rd_q && wr_q));
    a_one_completion: assert property (@(posedge clk) disable iff (!reset_n)
        !(ack_q && err_q));

endmodule

// File: tb/tb_iopage_ctl.sv
// Bench for iopage_ctl: bootrom/stub responders, a transaction-level
// latency model, per-cycle comparison and randomized traffic.
module tb_iopage_ctl;
    import iopage_pkg::*;

    localparam int SET = 1;
    localparam int TMO = 15;
    localparam logic [12:0] STUB_A = 13'o17570;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    iopage_ctl_if bus ();

    iopage_ctl #(.SETTLE(SET), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responders: bootrom at 13000-13777, one stub register at 17570.
    logic [15:0] stub_q    = '0;
    int          busy_cnt  = 0;
    int          dec_delay = 0;

    function automatic logic is_stub(input logic [12:0] a);
        return a[12:1] == STUB_A[12:1];
    endfunction

    function automatic logic is_rom(input logic [12:0] a);
        return (a >= 13'o13000) && (a <= 13'o13777);
    endfunction

    function automatic logic [15:0] rom_w(input logic [12:0] a);
        logic [12:0] e;
        e = {a[12:1], 1'b0};
        if (e == 13'o13000) return 16'o010000;
        if (e == 13'o13002) return 16'o012706;
        return ({3'b000, e} * 16'd37) ^ 16'h3c5a;
    endfunction

    function automatic logic [15:0] resp(input logic [12:0] a, input logic bop, input logic [15:0] sv);
        logic [15:0] w;
        w = is_stub(a) ? sv : rom_w(a);
        if (bop) return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
        return w;
    endfunction

    always @(posedge clk) begin
        busy_cnt <= bus.busy ? busy_cnt + 1 : 0;
        if (bus.iopage_wr && bus.iopage_decode && is_stub(bus.iopage_addr)) begin
            if (!bus.iopage_byte_op)      stub_q       <= bus.iopage_data_out;
            else if (bus.iopage_addr[0])  stub_q[15:8] <= bus.iopage_data_out[15:8];
            else                          stub_q[7:0]  <= bus.iopage_data_out[7:0];
        end
    end

    always_comb begin
        bus.iopage_decode  = 1'b0;
        bus.iopage_data_in = '0;
        if (bus.busy && (is_rom(bus.iopage_addr) || is_stub(bus.iopage_addr)) && busy_cnt >= dec_delay) begin
            bus.iopage_decode  = 1'b1;
            bus.iopage_data_in = resp(bus.iopage_addr, bus.iopage_byte_op, stub_q);
        end
    end

    // Transaction model: outcome and completion cycle relative to acceptance.
    int          t0    = 0;
    int          e_end = -1;
    logic        e_err = 1'b0, e_we = 1'b0, e_odd = 1'b1, e_bop = 1'b0;
    logic [12:0] e_addr = '0;
    logic [15:0] e_dout = '0, e_rnew = '0, e_rold = '0, m_stub = '0;
    int          ack_k = -1, err_k = -1, wr_k = -1;
    logic [15:0] wr_dout = '0;
    logic        chk_en = 1'b0;
    int          total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic predict(input logic we, input logic bop, input logic [12:0] a,
                           input logic [15:0] wd, input int dly);
        int samp;
        if (e_end >= 0 && !e_err && !e_we) e_rold = e_rnew;
        e_we   = we;
        e_bop  = bop;
        e_addr = a;
        e_odd  = !bop && a[0];
        e_dout = bop ? {wd[7:0], wd[7:0]} : wd;
        e_rnew = e_rold;
        if (e_odd) begin
            e_end = 1;
            e_err = 1'b1;
        end else begin
            samp = (1 + dly > 1 + SET) ? 1 + dly : 1 + SET;
            if ((is_rom(a) || is_stub(a)) && samp <= 1 + TMO) begin
                e_err = 1'b0;
                e_end = samp + (we ? 2 : 1);
                if (!we) e_rnew = resp(a, bop, m_stub);
                else if (is_stub(a)) begin
                    if (!bop)      m_stub       = wd;
                    else if (a[0]) m_stub[15:8] = wd[7:0];
                    else           m_stub[7:0]  = wd[7:0];
                end
            end else begin
                e_err = 1'b1;
                e_end = 2 + TMO;
            end
        end
    endtask

    task automatic start(input logic we, input logic bop, input logic [12:0] a,
                         input logic [15:0] wd, input int dly);
        @(posedge clk); #2;
        predict(we, bop, a, wd, dly);
        dec_delay   = dly;
        t0          = cyc;
        bus.req     = 1'b1;
        bus.we      = we;
        bus.byte_op = bop;
        bus.addr    = a;
        bus.wdata   = wd;
        @(posedge clk); #2;
        bus.req     = 1'b0;
        bus.addr    = 13'($urandom);
        bus.wdata   = 16'($urandom);
        bus.we      = 1'($urandom);
        bus.byte_op = 1'($urandom);
    endtask

    task automatic txn(input logic we, input logic bop, input logic [12:0] a,
                       input logic [15:0] wd, input int dly, input logic bogus);
        start(we, bop, a, wd, dly);
        if (bogus && e_end >= 5) begin
            @(posedge clk); #2;
            @(posedge clk); #2;
            bus.req     = 1'b1;
            bus.addr    = 13'o13001;
            bus.byte_op = 1'b0;
            bus.we      = 1'b0;
            @(posedge clk); #2;
            bus.req     = 1'b0;
        end
        while (cyc < t0 + e_end + 2) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.byte_op = 1'b0; bus.addr = '0; bus.wdata = '0;

        fork
            forever begin : compare
                int k;
                logic [15:0] exp_rd;
                @(negedge clk);
                if (chk_en) begin
                    k = cyc - t0;
                    if (k == 0) begin ack_k = -1; err_k = -1; wr_k = -1; end
                    exp_rd = (e_end >= 0 && k >= e_end && !e_err && !e_we) ? e_rnew : e_rold;
                    chk("busy",    32'(bus.busy),      32'(k >= 1 && k <= e_end));
                    chk("ack",     32'(bus.ack),       32'(k == e_end && !e_err));
                    chk("bus_err", 32'(bus.bus_err),   32'(k == e_end && e_err));
                    chk("rd",      32'(bus.iopage_rd), 32'(!e_we && !e_odd && k >= 1 && k <= e_end - 1));
                    chk("wr",      32'(bus.iopage_wr), 32'(e_we && !e_odd && !e_err && k == e_end - 1));
                    chk("rdata",   32'(bus.rdata),     32'(exp_rd));
                    if (k >= 1 && k <= e_end && !e_odd) begin
                        chk("iop_addr", 32'(bus.iopage_addr),     32'(e_addr));
                        chk("iop_dout", 32'(bus.iopage_data_out), 32'(e_dout));
                        chk("iop_byte", 32'(bus.iopage_byte_op),  32'(e_bop));
                    end
                    if (bus.iopage_wr) chk("wr_decode", 32'(bus.iopage_decode), 32'd1);
                    if (bus.ack) ack_k = k;
                    if (bus.bus_err) err_k = k;
                    if (bus.iopage_wr) begin wr_k = k; wr_dout = bus.iopage_data_out; end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_rdata", 32'(bus.rdata),       32'd0);
        chk("rst_addr",  32'(bus.iopage_addr), 32'd0);
        chk("rst_rd",    32'(bus.iopage_rd),   32'd0);
        chk("rst_ack",   32'(bus.ack),         32'd0);
        reset_n = 1'b1;
        t0 = cyc; e_end = -1; chk_en = 1'b1;

        txn(1'b0, 1'b0, 13'o13002, 16'h0000, 0, 1'b0);
        chk("wrd_rdata", 32'(bus.rdata), 32'o012706);
        chk("wrd_ack_k", 32'(ack_k),     32'd3);

        txn(1'b0, 1'b1, 13'o13003, 16'h0000, 0, 1'b0);
        chk("brd_hi", 32'(bus.rdata), 32'o000025);
        txn(1'b0, 1'b1, 13'o13002, 16'h0000, 0, 1'b0);
        chk("brd_lo", 32'(bus.rdata), 32'o000306);

        txn(1'b0, 1'b0, 13'o00000, 16'h0000, 0, 1'b0);
        chk("tmo_err_k", 32'(err_k), 32'd17);
        chk("tmo_noack", 32'(ack_k), 32'hffff_ffff);

        txn(1'b1, 1'b0, 13'o13001, 16'h1234, 0, 1'b0);
        chk("odd_err_k", 32'(err_k), 32'd1);
        chk("odd_nowr",  32'(wr_k),  32'hffff_ffff);

        txn(1'b1, 1'b1, STUB_A, 16'o000123, 0, 1'b0);
        chk("bwr_dout",  32'(wr_dout), 32'o051523);
        chk("bwr_wr_k",  32'(wr_k),    32'd3);
        chk("bwr_ack_k", 32'(ack_k),   32'd4);
        chk("bwr_stub",  32'(stub_q),  32'o000123);

        txn(1'b0, 1'b0, 13'o13000, 16'h0000, 4, 1'b1);
        chk("slow_ack_k", 32'(ack_k), 32'd6);

        // Reset in the middle of a read's address phase.
        start(1'b0, 1'b0, 13'o13002, 16'h0000, 30);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_rst_rd", 32'(bus.iopage_rd), 32'd1);
        chk_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("ar_rd",    32'(bus.iopage_rd),       32'd0);
        chk("ar_wr",    32'(bus.iopage_wr),       32'd0);
        chk("ar_busy",  32'(bus.busy),            32'd0);
        chk("ar_ack",   32'(bus.ack),             32'd0);
        chk("ar_err",   32'(bus.bus_err),         32'd0);
        chk("ar_rdata", 32'(bus.rdata),           32'd0);
        chk("ar_addr",  32'(bus.iopage_addr),     32'd0);
        chk("ar_dout",  32'(bus.iopage_data_out), 32'd0);
        chk("ar_byte",  32'(bus.iopage_byte_op),  32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        e_end = -1; e_rold = '0; e_rnew = '0; e_odd = 1'b1; e_err = 1'b0; t0 = cyc;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        txn(1'b0, 1'b0, 13'o13000, 16'h0000, 0, 1'b0);
        chk("post_rst_rdata", 32'(bus.rdata), 32'o010000);

        for (int i = 0; i < 80; i++) begin
            logic        rwe, rbop, rbog;
            logic [12:0] ra;
            logic [15:0] rwd;
            int          rdly;
            rwe  = 1'($urandom);
            rbop = 1'($urandom);
            rbog = 1'($urandom);
            rwd  = 16'($urandom);
            case ($urandom % 4)
                0, 3:    ra = 13'o13000 + 13'($urandom % 512);
                1:       ra = STUB_A | 13'($urandom % 2);
                default: ra = 13'($urandom);
            endcase
            rdly = ($urandom % 6 == 0) ? 10 + int'($urandom % 11) : int'($urandom % 5);
            txn(rwe, rbop, ra, rwd, rdly, rbog);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iopage_ctl.md
Name: iopage_ctl

Overview:
- CPU-side initiator for the 8 KB I/O page.
- Turns one CPU request (read/write, word/byte) into an iopage bus cycle, using the iopage_addr / iopage_rd / iopage_wr / iopage_byte_op signals.
- Collects the OR'ed decode and data returned by responders such as bootrom, the RK11 registers and the console.
- Ends every request with exactly one of: ack with read data, or a bus_err pulse (no decode before timeout, or odd-address word access).

Parameters:
- SETTLE, 1: minimum ADDR-state cycles after which decode/data are sampled.
- TIMEOUT, 15: ADDR-state cycle count with no decode before bus error; must be > SETTLE; counter width 5 bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  CPU request; sampled only in IDLE
- we  in  1  1 = write, 0 = read
- byte_op  in  1  byte access
- addr  in  13  iopage offset (byte address)
- wdata  in  16  write data (byte in [7:0] when byte_op)
- rdata  out  16  read data, valid with ack
- ack  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle error pulse
- busy  out  1  high in any state other than IDLE
- iopage_addr  out  13  registered address to responders
- iopage_data_out  out  16  write data to responders
- iopage_rd  out  1  read strobe
- iopage_wr  out  1  write strobe
- iopage_byte_op  out  1  byte qualifier
- iopage_data_in  in  16  OR of responder data_out
- iopage_decode  in  1  OR of responder decode

Behaviour:
- Asynchronous reset (reset_n = 0) forces all of the following, and returns the FSM to IDLE from any state; the strobes drop immediately with no completion pulse:
  - state = IDLE
  - rdata = 0, ack = 0, bus_err = 0, busy = 0
  - iopage_addr = 0, iopage_data_out = 0
  - iopage_rd = 0, iopage_wr = 0, iopage_byte_op = 0
  - cnt = 0
- States: IDLE, ADDR, WRITE, DONE, ERR. All outputs are registered.
- IDLE:
  - On req with byte_op = 0 and addr[0] = 1: go to ERR. No strobe is ever asserted.
  - On any other req: latch addr, we and byte_op; drive iopage_data_out = byte_op ? {wdata[7:0], wdata[7:0]} : wdata; cnt = 0.
  - For a read, assert iopage_rd at the same edge; then go to ADDR.
- ADDR:
  - cnt increments each cycle, saturating at TIMEOUT.
  - If cnt >= SETTLE and iopage_decode = 1:
    - Read: rdata <= iopage_data_in, drop iopage_rd, go to DONE.
    - Write: go to WRITE.
  - Else if cnt == TIMEOUT and iopage_decode = 0: drop iopage_rd, go to ERR.
  - decode is ignored while cnt < SETTLE.
- WRITE: iopage_wr = 1 for exactly this one cycle, then go to DONE. Addr, data and byte_op stay stable throughout.
- DONE: ack = 1 for one cycle, then go to IDLE.
- ERR: bus_err = 1 for one cycle, then go to IDLE; rdata is unchanged.
- Latency, with req accepted at cycle 0:
  - Read ack at cycle 2+SETTLE.
  - Write ack at cycle 3+SETTLE.
  - Timeout bus_err at cycle 2+TIMEOUT.
  - Odd-address bus_err at cycle 1.
- iopage_wr is never asserted without iopage_decode having been sampled high.
- iopage_rd and iopage_wr are never both high.
- req while busy is ignored. Back-to-back requests: a new req is accepted in the IDLE cycle following ack or bus_err.
- Byte reads: responders return the zero-extended byte, so rdata is passed through unmodified.

Decomposition:
- Package iopage_pkg:
  - state encoding
  - IOPAGE_AW = 13
  - data width 16
  - default SETTLE and TIMEOUT constants
- No sub-module: the counter and FSM form one module.

Test Plan:
- With bootrom attached:
  - Word read of addr 13002 → rdata = 012706, ack at cycle 3, iopage_rd high in cycles 1–2 only.
  - Byte read of 13003 → rdata = 000025.
  - Byte read of 13002 → rdata = 000306.
- Word read of addr 00000 with no responder → bus_err at cycle 17, no ack, iopage_rd high in cycles 1–16 then low.
- Word write of addr 13001 (odd) → bus_err at cycle 1; iopage_rd and iopage_wr never asserted.
- Byte write of wdata = 000123 to a stub register at 17570 (decode = 1) → iopage_data_out = 051523, iopage_wr high exactly one cycle (cycle 3), ack at cycle 4, stub latches 123.
- Stub responder asserting decode only from its 4th ADDR cycle → read ack at cycle 6; a second req issued at cycle 3 is ignored.
- reset_n low during ADDR of a read → iopage_rd low immediately and no ack/bus_err. After release, a new read of 13000 returns 010000.
